deser8_rx: RTL

- Serial-to-parallel receiver: the receive end of the team's 8-bit shift datapath.
- Accepts one bit per qualified clock, assembles a byte in either bit order, and presents it on a registered parallel output with a valid/ready handshake.
- Overrun detection and a synchronous clear are included.
- Sits between a serial link and an 8-bit register-based consumer.

---
 rtl/deser8_rx.sv | 97 +++++++++
 1 files changed

// File: rtl/deser8_rx.sv
// Serial-to-parallel receiver: assembles W serial bits (MSB- or LSB-first) into a
// registered word on d_out, with sticky overrun and a synchronous frame abort.
module deser8_rx #(
  parameter int W = 8,
  localparam int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_valid,
  input  logic          s_data,
  input  logic          msb_first,
  input  logic          clear,
  input  logic          d_ready,
  output logic [W-1:0]  d_out,
  output logic          d_valid,
  output logic          overrun,
  output logic [CW-1:0] bit_cnt,
  output logic          state_dbg
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  shreg, shreg_nxt, shifted;
  logic [CW-1:0] cnt_nxt;
  logic          order_msb, order_nxt, order_cur;
  logic          complete, load, drop;

  // Handshake: a word transfers on any edge where d_valid=1 and d_ready=1;
  // d_out is held stable while d_valid=1 and d_ready=0.
  assign state_dbg = (state == SHIFT);

  always_comb begin
    order_cur = (state == IDLE) ? msb_first : order_msb;
    shifted   = order_cur ? {shreg[W-2:0], s_data} : {s_data, shreg[W-1:1]};
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shreg_nxt = shreg;
    order_nxt = order_msb;
    complete  = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      shreg_nxt = '0;
    end else if (s_valid) begin
      shreg_nxt = shifted;
      order_nxt = order_cur;
      case (state)
        IDLE: begin
          state_nxt = SHIFT;
          cnt_nxt   = CW'(1);
        end
        SHIFT: begin
          if (bit_cnt == CW'(W - 1)) begin
            complete  = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = bit_cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A completing word either replaces a word being consumed this edge, fills an
  // empty output, or is dropped because the consumer is stalled.
  assign load = complete && (!d_valid || d_ready);
  assign drop = complete && d_valid && !d_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      order_msb <= 1'b1;
      d_out     <= '0;
      d_valid   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      shreg     <= shreg_nxt;
      order_msb <= order_nxt;
      if (load) begin
        d_out   <= shifted;
        d_valid <= 1'b1;
      end else if (d_valid && d_ready) begin
        d_valid <= 1'b0;
      end
      if (clear) overrun <= 1'b0;
      else if (drop) overrun <= 1'b1;
    end
  end

endmodule
